// File: rtl/sdram_arbiter.sv
// Shared SDRAM byte-port scheduler: four requesters (DMA, tape, FDC, CPU) are
// serialised into one sram command stream with fixed priority, CPU anti-starvation and timeout.
module sdram_arbiter #(
  parameter int AW           = 25,
  parameter int CPU_MAX_WAIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          dma_ack,
  input  logic          tape_req,
  input  logic [AW-1:0] tape_addr,
  output logic          tape_ack,
  input  logic          fdd_req,
  input  logic [AW-1:0] fdd_addr,
  output logic          fdd_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          timeout_err
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int CWW = (CPU_MAX_WAIT < 2) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WCW-1:0] TMO  = WCW'(TIMEOUT);
  localparam logic [CWW-1:0] CMAX = CWW'(CPU_MAX_WAIT);

  localparam logic [1:0] OWN_DMA  = 2'd0;
  localparam logic [1:0] OWN_TAPE = 2'd1;
  localparam logic [1:0] OWN_FDD  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]    owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } acc_t;

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wcnt;
  logic [CWW-1:0] r_cpu_wait;
  logic [3:0]     r_ack;
  logic [1:0]     r_grant;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [7:0]     r_din;
  logic [7:0]     r_rdata;
  logic           r_mem_rd, r_mem_we, r_busy, r_tmo_err;

  acc_t           w_pick;
  logic           w_any, w_promo, w_start, w_finish, w_tmo;
  logic           w_cpu_win, w_cpu_owned;

  assign w_any   = dma_req | tape_req | fdd_req | cpu_req;
  assign w_promo = (r_cpu_wait == CMAX);

  // DMA is never demoted; a starved CPU only jumps tape and fdd.
  always_comb begin
    w_pick = '0;
    if (dma_req) begin
      w_pick = '{owner: OWN_DMA, we: dma_we, addr: dma_addr, din: dma_din};
    end else if (cpu_req && w_promo) begin
      w_pick = '{owner: OWN_CPU, we: cpu_we, addr: cpu_addr, din: cpu_din};
    end else if (tape_req) begin
      w_pick = '{owner: OWN_TAPE, we: 1'b0, addr: tape_addr, din: 8'h00};
    end else if (fdd_req) begin
      w_pick = '{owner: OWN_FDD, we: 1'b0, addr: fdd_addr, din: 8'h00};
    end else if (cpu_req) begin
      w_pick = '{owner: OWN_CPU, we: cpu_we, addr: cpu_addr, din: cpu_din};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && mem_ready) begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // wcnt==0 is the arm cycle: the sram may not have dropped ready yet.
        if ((r_wcnt != '0) && mem_ready) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_wcnt == TMO) begin
          w_finish    = 1'b1;
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cpu_win   = w_start && (w_pick.owner == OWN_CPU);
  assign w_cpu_owned = (r_state != S_IDLE) && (r_grant == OWN_CPU);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_cpu_wait <= '0;
      r_ack      <= '0;
      r_grant    <= OWN_DMA;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_rdata    <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_mem_rd <= 1'b0;
      r_mem_we <= 1'b0;
      r_ack    <= '0;

      if (w_start) begin
        r_grant  <= w_pick.owner;
        r_we     <= w_pick.we;
        r_addr   <= w_pick.addr;
        r_din    <= w_pick.din;
        r_mem_rd <= ~w_pick.we;
        r_mem_we <= w_pick.we;
      end

      if (r_state == S_ISSUE) r_wcnt <= '0;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;

      if (w_finish) begin
        r_ack[r_grant] <= 1'b1;
        if (w_tmo) begin
          r_rdata   <= 8'hFF;
          r_tmo_err <= 1'b1;
        end else if (!r_we) begin
          r_rdata <= mem_dout;
        end
      end

      if (!cpu_req || w_cpu_win) r_cpu_wait <= '0;
      else if (!w_cpu_owned && (r_cpu_wait != CMAX)) r_cpu_wait <= r_cpu_wait + 1'b1;
    end
  end

  assign dma_ack     = r_ack[OWN_DMA];
  assign tape_ack    = r_ack[OWN_TAPE];
  assign fdd_ack     = r_ack[OWN_FDD];
  assign cpu_ack     = r_ack[OWN_CPU];
  assign rdata       = r_rdata;
  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign mem_rd      = r_mem_rd;
  assign mem_we      = r_mem_we;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single read, priority ordering, CPU promotion,
// timeout, reset mid-access and back-to-back minimum latency.
module tb_sdram_arbiter;
  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din;
  logic          tape_req, tape_ack;
  logic [AW-1:0] tape_addr;
  logic          fdd_req, fdd_ack;
  logic [AW-1:0] fdd_addr;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;
  logic          mem_rd, mem_we, mem_ready;
  logic [1:0]    grant;
  logic          busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt, we_cnt, rd_cnt;

  always #5 clk_sys = ~clk_sys;

  sdram_arbiter #(.AW(AW), .CPU_MAX_WAIT(8), .TIMEOUT(255)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(dma_ack),
    .tape_req(tape_req), .tape_addr(tape_addr), .tape_ack(tape_ack),
    .fdd_req(fdd_req), .fdd_addr(fdd_addr), .fdd_ack(fdd_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    ack_cnt += int'(dma_ack) + int'(tape_ack) + int'(fdd_ack) + int'(cpu_ack);
    we_cnt  += int'(mem_we);
    rd_cnt  += int'(mem_rd);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_cnt();
    ack_cnt = 0;
    we_cnt  = 0;
    rd_cnt  = 0;
  endtask

  initial begin
    reset = 1'b1;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_din = '0;
    tape_req = 1'b0; tape_addr = '0;
    fdd_req = 1'b0; fdd_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    mem_dout = 8'h00; mem_ready = 1'b1;
    clr_cnt();
    ticks(2);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rd_we", 32'({mem_rd, mem_we}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    chk("rst_acks", 32'({dma_ack, tape_ack, fdd_ack, cpu_ack}), 32'h0);
    reset = 1'b0;
    tick();

    // single CPU read, memory busy for three cycles
    clr_cnt();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h014000;
    tick();
    chk("t1_rd", 32'(mem_rd), 32'h1);
    chk("t1_grant", 32'(grant), 32'h3);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h014000);
    mem_ready = 1'b0;
    tick();
    chk("t1_rd_once", 32'(mem_rd), 32'h0);
    ticks(2);
    mem_ready = 1'b1; mem_dout = 8'h5A;
    tick();
    chk("t1_ack", 32'(cpu_ack), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'h5A);
    chk("t1_acks", 32'(ack_cnt), 32'd1);
    chk("t1_rds", 32'(rd_cnt), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("t1_idle", 32'(busy), 32'h0);

    // simultaneous dma write, tape read, cpu read
    clr_cnt();
    mem_dout = 8'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h181FFF; dma_din = 8'hC3;
    tape_req = 1'b1; tape_addr = 25'h000100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000200;
    tick();
    chk("t2_dma_grant", 32'(grant), 32'h0);
    chk("t2_dma_we", 32'({mem_we, mem_rd}), 32'h2);
    chk("t2_dma_addr", 32'(mem_addr), 32'h181FFF);
    chk("t2_dma_din", 32'(mem_din), 32'hC3);
    tick();
    chk("t2_we_drop", 32'(mem_we), 32'h0);
    ticks(2);
    chk("t2_dma_ack", 32'(dma_ack), 32'h1);
    chk("t2_rdata_kept", 32'(rdata), 32'h5A);
    dma_req = 1'b0;
    ticks(2);
    chk("t2_tape_grant", 32'(grant), 32'h1);
    chk("t2_tape_rd", 32'(mem_rd), 32'h1);
    chk("t2_tape_din", 32'(mem_din), 32'h0);
    ticks(3);
    chk("t2_tape_ack", 32'(tape_ack), 32'h1);
    chk("t2_tape_rdata", 32'(rdata), 32'h11);
    tape_req = 1'b0; mem_dout = 8'h22;
    ticks(2);
    chk("t2_cpu_grant", 32'(grant), 32'h3);
    ticks(3);
    chk("t2_cpu_ack", 32'(cpu_ack), 32'h1);
    chk("t2_cpu_rdata", 32'(rdata), 32'h22);
    cpu_req = 1'b0;
    ticks(2);
    chk("t2_acks", 32'(ack_cnt), 32'd3);
    chk("t2_we_cycles", 32'(we_cnt), 32'd1);
    chk("t2_idle", 32'(busy), 32'h0);

    // CPU starvation: tape held continuously
    clr_cnt();
    mem_dout = 8'h33;
    tape_req = 1'b1; tape_addr = 25'h000300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000400;
    tick();
    chk("t3_g0", 32'(grant), 32'h1);
    ticks(5);
    chk("t3_g1", 32'(grant), 32'h1);
    chk("t3_rd1", 32'(mem_rd), 32'h1);
    ticks(4);
    chk("t3_wait_sat", 32'(dut.r_cpu_wait), 32'd8);
    tick();
    chk("t3_cpu_promoted", 32'(grant), 32'h3);
    chk("t3_cpu_addr", 32'(mem_addr), 32'h000400);
    chk("t3_wait_clr", 32'(dut.r_cpu_wait), 32'd0);
    ticks(3);
    chk("t3_cpu_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0; tape_req = 1'b0;
    ticks(2);
    chk("t3_acks", 32'(ack_cnt), 32'd3);
    chk("t3_wait_after", 32'(dut.r_cpu_wait), 32'd0);
    chk("t3_idle", 32'(busy), 32'h0);

    // timeout on an fdd read
    clr_cnt();
    fdd_req = 1'b1; fdd_addr = 25'h000500;
    tick();
    chk("t4_grant", 32'(grant), 32'h2);
    chk("t4_rd", 32'(mem_rd), 32'h1);
    mem_ready = 1'b0;
    tick();
    ticks(255);
    chk("t4_no_ack_early", 32'(fdd_ack), 32'h0);
    chk("t4_busy", 32'(busy), 32'h1);
    tick();
    chk("t4_ack_256", 32'(fdd_ack), 32'h1);
    chk("t4_rdata_ff", 32'(rdata), 32'hFF);
    chk("t4_terr", 32'(timeout_err), 32'h1);
    fdd_req = 1'b0; mem_ready = 1'b1;
    ticks(3);
    chk("t4_terr_sticky", 32'(timeout_err), 32'h1);
    chk("t4_idle", 32'(busy), 32'h0);

    // reset during WAIT of a dma write
    clr_cnt();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h000600; dma_din = 8'h77;
    tick();
    chk("t5_we", 32'(mem_we), 32'h1);
    mem_ready = 1'b0;
    ticks(2);
    chk("t5_in_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_terr", 32'(timeout_err), 32'h0);
    chk("t5_rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    ticks(2);
    chk("t5_hold_busy", 32'(busy), 32'h0);
    chk("t5_hold_we", 32'(mem_we), 32'h0);
    chk("t5_no_ack", 32'(ack_cnt), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("t5_reissue", 32'(mem_we), 32'h1);
    chk("t5_readdr", 32'(mem_addr), 32'h000600);
    ticks(3);
    chk("t5_ack", 32'(dma_ack), 32'h1);
    dma_req = 1'b0;
    ticks(2);

    // minimum latency back-to-back CPU reads
    clr_cnt();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000700;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("t6_ack_c%0d", i), 32'(cpu_ack), ((i % 5) == 4) ? 32'h1 : 32'h0);
    end
    cpu_req = 1'b0;
    tick();
    chk("t6_acks", 32'(ack_cnt), 32'd4);
    chk("t6_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
